wdt_supervisor: RTL and testbench

WDT_SUPERVISOR -- requirements
Module: wdt_supervisor

---
 rtl/wdt_supervisor_if.sv | 37 +++
 rtl/wdt_supervisor.sv | 144 ++++++++++++++
 tb/tb_wdt_supervisor.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wdt_supervisor_if.sv
// Signal bundle between wdt_supervisor and its environment (task check-ins, config, watchdog link).
// master drives the inputs of the supervisor, slave is the supervisor side.
interface wdt_supervisor_if #(
    parameter int N_TASKS = 4
);
    logic                i_arm;
    logic [N_TASKS-1:0]  i_task_en;
    logic [N_TASKS-1:0]  i_checkin;
    logic                i_cfg_we;
    logic [31:0]         i_cfg_wait;
    logic [31:0]         i_cfg_rst;
    logic                i_wdt_hw_rst;
    logic                i_log_clr;

    logic                o_clrwdt;
    logic [31:0]         o_wait_period;
    logic [31:0]         o_rst_period;
    logic                o_cfg_ack;
    logic                o_cfg_err;
    logic [1:0]          o_state;
    logic [N_TASKS-1:0]  o_missed;
    logic [7:0]          o_rst_cnt;

    modport master (
        output i_arm, i_task_en, i_checkin, i_cfg_we, i_cfg_wait, i_cfg_rst,
               i_wdt_hw_rst, i_log_clr,
        input  o_clrwdt, o_wait_period, o_rst_period, o_cfg_ack, o_cfg_err,
               o_state, o_missed, o_rst_cnt
    );

    modport slave (
        input  i_arm, i_task_en, i_checkin, i_cfg_we, i_cfg_wait, i_cfg_rst,
               i_wdt_hw_rst, i_log_clr,
        output o_clrwdt, o_wait_period, o_rst_period, o_cfg_ack, o_cfg_err,
               o_state, o_missed, o_rst_cnt
    );
endinterface

// File: rtl/wdt_supervisor.sv
// Kicks the watchdog only after every enabled task checked in; optional miss log under WDT_SUP_MISS_LOG_EN.
// Latency: kick pulse one edge after the round completes; config result one cycle after the write.
// Backpressure: none; check-ins are pulses, writes outside IDLE are refused with o_cfg_err.
module wdt_supervisor #(
    parameter int          N_TASKS  = 4,
    parameter logic [31:0] DEF_WAIT = 32'd1000,
    parameter logic [31:0] DEF_RST  = 32'd16,
    parameter int          MIN_GAP  = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    wdt_supervisor_if.slave  bus
);
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_COLLECT = 3'd1;
    localparam logic [2:0] ST_KICK    = 3'd2;
    localparam logic [2:0] ST_HOLDOFF = 3'd3;
    localparam logic [2:0] ST_RECOVER = 3'd4;

    localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    logic [2:0]         state, state_nxt;
    logic [N_TASKS-1:0] seen, seen_nxt;
    logic [N_TASKS-1:0] live;
    logic [GW-1:0]      gap, gap_nxt;
    logic               all_in;

    assign live   = bus.i_checkin & bus.i_task_en;
    assign all_in = (bus.i_task_en != '0) && ((seen & bus.i_task_en) == bus.i_task_en);

    always_comb begin
        state_nxt = state;
        seen_nxt  = seen;
        gap_nxt   = gap;
        if (!bus.i_arm) begin
            state_nxt = ST_IDLE;
            seen_nxt  = '0;
            gap_nxt   = '0;
        end else if (bus.i_wdt_hw_rst && state != ST_IDLE) begin
            state_nxt = ST_RECOVER;
            seen_nxt  = '0;
            gap_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_COLLECT;
                    seen_nxt  = '0;
                end
                ST_COLLECT: begin
                    seen_nxt = seen | live;
                    if (all_in) state_nxt = ST_KICK;
                end
                ST_KICK: begin
                    state_nxt = ST_HOLDOFF;
                    seen_nxt  = live;
                    gap_nxt   = GW'(MIN_GAP - 1);
                end
                ST_HOLDOFF: begin
                    seen_nxt = seen | live;
                    // Leave as the counter reaches zero, giving exactly MIN_GAP+1 between kicks.
                    if (gap <= GW'(1)) begin
                        gap_nxt   = '0;
                        state_nxt = ST_COLLECT;
                    end else begin
                        gap_nxt = gap - GW'(1);
                    end
                end
                ST_RECOVER: state_nxt = ST_COLLECT;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
            seen  <= '0;
            gap   <= '0;
        end else begin
            state <= state_nxt;
            seen  <= seen_nxt;
            gap   <= gap_nxt;
        end
    end

    // Periods only change while idle so the watchdog never sees a mid-run update.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bus.o_wait_period <= DEF_WAIT;
            bus.o_rst_period  <= DEF_RST;
            bus.o_cfg_ack     <= 1'b0;
            bus.o_cfg_err     <= 1'b0;
        end else begin
            bus.o_cfg_ack <= 1'b0;
            bus.o_cfg_err <= 1'b0;
            if (bus.i_cfg_we) begin
                if (state == ST_IDLE && bus.i_cfg_wait != 32'd0) begin
                    bus.o_wait_period <= bus.i_cfg_wait;
                    bus.o_rst_period  <= bus.i_cfg_rst;
                    bus.o_cfg_ack     <= 1'b1;
                end else begin
                    bus.o_cfg_err <= 1'b1;
                end
            end
        end
    end

    assign bus.o_clrwdt = (state == ST_KICK);

    always_comb begin
        case (state)
            ST_IDLE:              bus.o_state = 2'd0;
            ST_COLLECT:           bus.o_state = 2'd1;
            ST_KICK, ST_HOLDOFF:  bus.o_state = 2'd2;
            default:              bus.o_state = 2'd3;
        endcase
    end

`ifdef WDT_SUP_MISS_LOG_EN
    logic enter_rec;
    assign enter_rec = bus.i_arm && bus.i_wdt_hw_rst &&
                       state != ST_IDLE && state != ST_RECOVER;

    // A miss recorded on the same edge as a clear survives the clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bus.o_missed  <= '0;
            bus.o_rst_cnt <= 8'd0;
        end else if (enter_rec) begin
            bus.o_missed <= (bus.i_log_clr ? '0 : bus.o_missed) | (bus.i_task_en & ~seen);
            if (bus.i_log_clr)
                bus.o_rst_cnt <= 8'd1;
            else if (bus.o_rst_cnt != 8'd255)
                bus.o_rst_cnt <= bus.o_rst_cnt + 8'd1;
        end else if (bus.i_log_clr) begin
            bus.o_missed  <= '0;
            bus.o_rst_cnt <= 8'd0;
        end
    end
`else
    assign bus.o_missed  = '0;
    assign bus.o_rst_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_wdt_supervisor.sv
// Directed bench for wdt_supervisor: behavioural model compared every cycle plus literal spot checks.
module tb_wdt_supervisor;
    localparam int N       = 4;
    localparam int MIN_GAP = 8;
    localparam int HOLD_CYC = (MIN_GAP > 1) ? MIN_GAP - 1 : 1;

    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    wdt_supervisor_if #(.N_TASKS(N)) bus();

    wdt_supervisor #(
        .N_TASKS (N),
        .DEF_WAIT(32'd1000),
        .DEF_RST (32'd16),
        .MIN_GAP (MIN_GAP)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_no  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc_no);
        end
    endtask

    // Behavioural model: armed / recovering / kicking / holdoff cycles left / which tasks reported.
    bit          m_armed, m_rec, m_kick;
    int          m_hold;
    logic [N-1:0] m_rep;
    logic [31:0] m_wait, m_rstp;
    bit          m_ack, m_err;
    logic [N-1:0] m_missed;
    int          m_cnt;

    function automatic bit round_done(input logic [N-1:0] rep, input logic [N-1:0] en);
        int need = 0;
        int got  = 0;
        for (int t = 0; t < N; t++) begin
            if (en[t]) begin
                need++;
                if (rep[t]) got++;
            end
        end
        return (need > 0) && (got == need);
    endfunction

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_armed <= 0; m_rec <= 0; m_kick <= 0; m_hold <= 0; m_rep <= '0;
            m_wait <= 32'd1000; m_rstp <= 32'd16; m_ack <= 0; m_err <= 0;
            m_missed <= '0; m_cnt <= 0;
        end else begin
            m_ack <= 0;
            m_err <= 0;
            if (bus.i_cfg_we) begin
                if (!m_armed && bus.i_cfg_wait != 0) begin
                    m_wait <= bus.i_cfg_wait;
                    m_rstp <= bus.i_cfg_rst;
                    m_ack  <= 1;
                end else begin
                    m_err <= 1;
                end
            end
`ifdef WDT_SUP_MISS_LOG_EN
            if (bus.i_arm && bus.i_wdt_hw_rst && m_armed && !m_rec) begin
                m_missed <= (bus.i_log_clr ? '0 : m_missed) | (bus.i_task_en & ~m_rep);
                m_cnt    <= bus.i_log_clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
            end else if (bus.i_log_clr) begin
                m_missed <= '0;
                m_cnt    <= 0;
            end
`endif
            if (!bus.i_arm) begin
                m_armed <= 0; m_rec <= 0; m_kick <= 0; m_hold <= 0; m_rep <= '0;
            end else if (bus.i_wdt_hw_rst && m_armed) begin
                m_rec <= 1; m_kick <= 0; m_hold <= 0; m_rep <= '0;
            end else if (!m_armed) begin
                m_armed <= 1; m_rep <= '0;
            end else if (m_rec) begin
                m_rec <= 0;
            end else if (m_kick) begin
                m_kick <= 0;
                m_hold <= HOLD_CYC;
                m_rep  <= bus.i_checkin & bus.i_task_en;
            end else if (m_hold > 0) begin
                m_hold <= m_hold - 1;
                m_rep  <= m_rep | (bus.i_checkin & bus.i_task_en);
            end else begin
                if (round_done(m_rep, bus.i_task_en)) m_kick <= 1;
                m_rep <= m_rep | (bus.i_checkin & bus.i_task_en);
            end
        end
    end

    always @(negedge i_clk) begin
        logic [1:0] exp_state;
        exp_state = !m_armed ? 2'd0 : m_rec ? 2'd3 : (m_kick || m_hold > 0) ? 2'd2 : 2'd1;
        chk("state",    32'(bus.o_state),   32'(exp_state));
        chk("clrwdt",   32'(bus.o_clrwdt),  32'(m_kick));
        chk("wait_per", bus.o_wait_period,  m_wait);
        chk("rst_per",  bus.o_rst_period,   m_rstp);
        chk("cfg_ack",  32'(bus.o_cfg_ack), 32'(m_ack));
        chk("cfg_err",  32'(bus.o_cfg_err), 32'(m_err));
        chk("missed",   32'(bus.o_missed),  32'(m_missed));
        chk("rst_cnt",  32'(bus.o_rst_cnt), 32'(m_cnt));
    end

    task automatic cyc(input logic [N-1:0] ci);
        bus.i_checkin = ci;
        @(negedge i_clk);
        cyc_no++;
    endtask

    initial begin
        int rises[$];
        int pulses;
        bit prev;

        i_rst = 1'b1;
        bus.i_arm = 0; bus.i_task_en = '0; bus.i_checkin = '0; bus.i_cfg_we = 0;
        bus.i_cfg_wait = '0; bus.i_cfg_rst = '0; bus.i_wdt_hw_rst = 0; bus.i_log_clr = 0;
        repeat (2) @(negedge i_clk);
        chk("rst_state",  32'(bus.o_state),  32'd0);
        chk("rst_clrwdt", 32'(bus.o_clrwdt), 32'd0);
        chk("rst_wait",   bus.o_wait_period, 32'd1000);
        chk("rst_rstp",   bus.o_rst_period,  32'd16);
        chk("rst_missed", 32'(bus.o_missed), 32'd0);
        chk("rst_cnt0",   32'(bus.o_rst_cnt), 32'd0);
        i_rst = 1'b0;

        // One check-in per task on consecutive cycles, kick two edges after the last.
        bus.i_arm = 1; bus.i_task_en = 4'hF;
        cyc(4'h0);
        chk("arm_collect", 32'(bus.o_state), 32'd1);
        cyc(4'h1); cyc(4'h2); cyc(4'h4); cyc(4'h8);
        chk("seq_no_kick_yet", 32'(bus.o_clrwdt), 32'd0);
        cyc(4'h0);
        chk("seq_kick", 32'(bus.o_clrwdt), 32'd1);
        cyc(4'h0);
        chk("seq_kick_one_cycle", 32'(bus.o_clrwdt), 32'd0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(4'h0);
            if (bus.o_clrwdt) pulses++;
        end
        chk("seq_single_pulse", 32'(pulses), 32'd0);

        // Continuous check-ins: kicks spaced MIN_GAP+1 apart.
        prev = bus.o_clrwdt;
        for (int i = 0; i < 40; i++) begin
            cyc(4'hF);
            if (bus.o_clrwdt && !prev) rises.push_back(cyc_no);
            prev = bus.o_clrwdt;
        end
        chk("gap_pulse_count_ge3", 32'(rises.size() >= 3), 32'd1);
        for (int i = 1; i < rises.size(); i++)
            chk("gap_spacing", 32'(rises[i] - rises[i-1]), 32'd9);

        // Partial mask: disabled tasks ignored, enabled subset completes the round.
        bus.i_arm = 0; cyc(4'h0);
        bus.i_arm = 1; bus.i_task_en = 4'b0101; cyc(4'h0);
        cyc(4'b1010); cyc(4'h0);
        chk("mask_disabled_ignored", 32'(bus.o_clrwdt), 32'd0);
        cyc(4'b0001); cyc(4'b0100); cyc(4'h0);
        chk("mask_kick", 32'(bus.o_clrwdt), 32'd1);

        // Empty mask never kicks.
        bus.i_arm = 0; cyc(4'h0);
        bus.i_arm = 1; bus.i_task_en = 4'h0; cyc(4'h0);
        pulses = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc(4'($urandom_range(0, 15)));
            if (bus.o_clrwdt) pulses++;
        end
        chk("en0_no_kick", 32'(pulses), 32'd0);
        chk("en0_collect", 32'(bus.o_state), 32'd1);

        // Configuration writes.
        bus.i_arm = 0; cyc(4'h0);
        bus.i_cfg_we = 1; bus.i_cfg_wait = 32'd50; bus.i_cfg_rst = 32'd4; cyc(4'h0);
        bus.i_cfg_we = 0;
        chk("cfg_idle_ack", 32'(bus.o_cfg_ack), 32'd1);
        chk("cfg_idle_wait", bus.o_wait_period, 32'd50);
        chk("cfg_idle_rst", bus.o_rst_period, 32'd4);
        bus.i_arm = 1; bus.i_task_en = 4'hF; cyc(4'h0);
        bus.i_cfg_we = 1; bus.i_cfg_wait = 32'd77; bus.i_cfg_rst = 32'd9; cyc(4'h0);
        bus.i_cfg_we = 0;
        chk("cfg_busy_err", 32'(bus.o_cfg_err), 32'd1);
        chk("cfg_busy_wait", bus.o_wait_period, 32'd50);
        bus.i_arm = 0; cyc(4'h0);
        bus.i_cfg_we = 1; bus.i_cfg_wait = 32'd0; bus.i_cfg_rst = 32'd7; cyc(4'h0);
        bus.i_cfg_we = 0;
        chk("cfg_zero_err", 32'(bus.o_cfg_err), 32'd1);
        chk("cfg_zero_rst", bus.o_rst_period, 32'd4);

        // Task 2 silent, watchdog fires: recovery and miss log.
        bus.i_arm = 1; cyc(4'h0);
        cyc(4'h1); cyc(4'h2); cyc(4'h8);
        bus.i_wdt_hw_rst = 1;
        cyc(4'h0);
        chk("rec_state", 32'(bus.o_state), 32'd3);
        cyc(4'h0); cyc(4'h0); cyc(4'h0);
        bus.i_wdt_hw_rst = 0;
        cyc(4'h0);
        chk("rec_back_collect", 32'(bus.o_state), 32'd1);
`ifdef WDT_SUP_MISS_LOG_EN
        chk("rec_missed", 32'(bus.o_missed), 32'h4);
        chk("rec_cnt", 32'(bus.o_rst_cnt), 32'd1);
`else
        chk("rec_missed_off", 32'(bus.o_missed), 32'h0);
        chk("rec_cnt_off", 32'(bus.o_rst_cnt), 32'd0);
`endif
        bus.i_log_clr = 1; cyc(4'h0);
        bus.i_log_clr = 0;
        chk("log_clr_missed", 32'(bus.o_missed), 32'h0);

        // Disarm during holdoff, reset during collect.
        cyc(4'hF); cyc(4'h0);
        chk("pre_hold_kick", 32'(bus.o_clrwdt), 32'd1);
        cyc(4'h0);
        chk("hold_state", 32'(bus.o_state), 32'd2);
        bus.i_arm = 0; cyc(4'h0);
        chk("disarm_idle", 32'(bus.o_state), 32'd0);
        chk("disarm_clrwdt", 32'(bus.o_clrwdt), 32'd0);
        bus.i_arm = 1; cyc(4'h0); cyc(4'h1); cyc(4'h2);
        #2 i_rst = 1'b1;
        #1;
        chk("async_rst_state", 32'(bus.o_state), 32'd0);
        chk("async_rst_wait", bus.o_wait_period, 32'd1000);
        @(negedge i_clk);
        #2 i_rst = 1'b0;
        @(negedge i_clk);
        cyc(4'h0);
        cyc(4'h4); cyc(4'h8); cyc(4'h0);
        chk("rst_discard_partial", 32'(bus.o_clrwdt), 32'd0);
        cyc(4'h1); cyc(4'h2); cyc(4'h0);
        chk("rst_full_round_kick", 32'(bus.o_clrwdt), 32'd1);
        cyc(4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
